// File: rtl/uart_tx_ctrl_if.sv
// Request side of the UART transmitter: byte, frame options and the ready/valid handshake.
interface uart_tx_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              parity_en;
  logic              parity_odd;
  logic              stop2;
  logic              tx_ready;

  modport master (
    output tx_valid, tx_data, parity_en, parity_odd, stop2,
    input  tx_ready
  );

  modport slave (
    input  tx_valid, tx_data, parity_en, parity_odd, stop2,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART frame transmitter: start bit, DATA_W data bits LSB first, optional parity,
// one or two stop bits, paced by an external one-cycle baud tick.
//
// state  | meaning
// IDLE   | line high, ready for a byte; bclk ignored
// SYNC   | byte captured, line high, waiting for the next baud tick
// START  | start bit (line low)
// DATA   | data bits, LSB first
// PARITY | parity bit over the captured data
// STOP   | stop bit(s), line high
module uart_tx_ctrl #(
  parameter int DATA_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           bclk,
  uart_tx_ctrl_if.slave  req,
  output logic           txd,
  output logic           busy,
  output logic           tx_done
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              par_en_q, par_en_d;
  logic              par_odd_q, par_odd_d;
  logic              stop2_q, stop2_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic              txd_q, txd_d;
  logic              tx_done_q, tx_done_d;
  logic              handshake;
  logic              parity_bit;

  assign req.tx_ready = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign handshake    = req.tx_valid && req.tx_ready;
  assign parity_bit   = (^data_q) ^ par_odd_q;
  assign txd          = txd_q;
  assign tx_done      = tx_done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      stop2_q    <= 1'b0;
      bit_idx_q  <= '0;
      stop_cnt_q <= 1'b0;
      txd_q      <= 1'b1;
      tx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      stop2_q    <= stop2_d;
      bit_idx_q  <= bit_idx_d;
      stop_cnt_q <= stop_cnt_d;
      txd_q      <= txd_d;
      tx_done_q  <= tx_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    stop2_d    = stop2_q;
    bit_idx_d  = bit_idx_q;
    stop_cnt_d = stop_cnt_q;
    unique case (state_q)
      IDLE: begin
        // A baud tick in the handshake cycle is deliberately dropped; SYNC waits for the next one.
        if (handshake) begin
          state_d   = SYNC;
          data_d    = req.tx_data;
          par_en_d  = req.parity_en;
          par_odd_d = req.parity_odd;
          stop2_d   = req.stop2;
        end
      end
      SYNC: begin
        if (bclk) state_d = START;
      end
      START: begin
        if (bclk) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (bclk) begin
          if (bit_idx_q == LAST_IDX) begin
            state_d    = par_en_q ? PARITY : STOP;
            stop_cnt_d = 1'b0;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bclk) begin
          state_d    = STOP;
          stop_cnt_d = 1'b0;
        end
      end
      STOP: begin
        if (bclk) begin
          if (stop2_q && !stop_cnt_q) stop_cnt_d = 1'b1;
          else                        state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // txd is registered from the next state so the line changes together with the state.
  always_comb begin
    tx_done_d = (state_q == STOP) && (state_d == IDLE);
    unique case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = data_q[bit_idx_d];
      PARITY:  txd_d = parity_bit;
      default: txd_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: frame traces against a bit-list model of the frame.
module tb_uart_tx_ctrl;

  typedef bit bitq_t[$];

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic bclk = 1'b0;
  logic txd, busy, tx_done;

  uart_tx_ctrl_if #(.DATA_W(8)) bus ();

  uart_tx_ctrl #(.DATA_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .bclk    (bclk),
    .req     (bus),
    .txd     (txd),
    .busy    (busy),
    .tx_done (tx_done)
  );

  int total = 0;
  int bad   = 0;

  int bper     = 16;
  int bcnt     = 0;
  bit bclk_man = 1'b0;

  logic bclk_seen = 1'b0;
  logic hs_seen   = 1'b0;

  always #5 clk = ~clk;

  // baud generator: one-cycle tick every bper cycles, changed away from the rising edge
  initial begin
    forever begin
      @(negedge clk);
      if (!bclk_man) begin
        bcnt = (bcnt >= bper - 1) ? 0 : bcnt + 1;
        bclk = (bcnt == 0);
      end
    end
  end

  always @(posedge clk) begin
    bclk_seen <= bclk;
    hs_seen   <= bus.tx_valid && bus.tx_ready && !rst;
  end

  // expected line level for each bit period of one frame
  function automatic bitq_t frame_bits(input logic [7:0] d, input bit pe, input bit po, input bit s2);
    bitq_t q;
    int ones;
    logic [7:0] v;
    v = d;
    ones = 0;
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      q.push_back(v[i]);
      if (v[i]) ones++;
    end
    if (pe) begin
      if (po) q.push_back((ones % 2) == 0);
      else    q.push_back((ones % 2) == 1);
    end
    q.push_back(1'b1);
    if (s2) q.push_back(1'b1);
    return q;
  endfunction

  task automatic run_frame(input logic [7:0] d, input bit pe, input bit po, input bit s2,
                           input bit hold, input logic [7:0] nd, input string nm,
                           output int hs_wait);
    bitq_t bits;
    int    n, ticks, mism, dones, len, first_at, limit;
    bit    started, exp_txd, exp_busy, exp_done;
    bits = frame_bits(d, pe, po, s2);
    n    = bits.size();
    bus.tx_data    = d;
    bus.parity_en  = pe;
    bus.parity_odd = po;
    bus.stop2      = s2;
    bus.tx_valid   = 1'b1;
    hs_wait = 0;
    do begin
      @(posedge clk); #1;
      hs_wait++;
    end while (!hs_seen && hs_wait < 400);
    total++;
    if (!hs_seen) begin
      bad++;
      $display("FAIL %s handshake: waited %0d cycles without handshake, required one within 400", nm, hs_wait);
      bus.tx_valid = 1'b0;
      return;
    end
    ticks = 0; mism = 0; dones = 0; len = 0; started = 1'b0; first_at = -1;
    limit = (n + 2) * (bper + 2) + 20;
    for (int c = 0; c < limit; c++) begin
      exp_txd  = (ticks == 0 || ticks > n) ? 1'b1 : bits[ticks-1];
      exp_busy = (ticks <= n);
      exp_done = (ticks == n + 1);
      if (txd !== exp_txd || busy !== exp_busy || tx_done !== exp_done ||
          bus.tx_ready !== (exp_busy ? 1'b0 : 1'b1)) begin
        mism++;
        if (first_at < 0) first_at = c;
      end
      if (tx_done === 1'b1) dones++;
      if (ticks == n + 1) break;
      if (hold) begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = nd;
      end else begin
        bus.tx_data    = 8'($urandom);
        bus.parity_en  = 1'($urandom);
        bus.parity_odd = 1'($urandom);
        bus.stop2      = 1'($urandom);
        bus.tx_valid   = (ticks < n - 1) ? 1'($urandom) : 1'b0;
      end
      @(posedge clk); #1;
      if (bclk_seen) ticks++;
      if (started && bclk_seen) len++;
      if (!started && txd === 1'b0) started = 1'b1;
    end
    if (ticks != n + 1) mism++;
    total++;
    if (mism != 0) begin
      bad++;
      $display("FAIL %s trace: %0d cycles differ (first at cycle %0d), required 0", nm, mism, first_at);
    end
    total++;
    if (dones != 1) begin
      bad++;
      $display("FAIL %s tx_done_count: got %0d pulses, required 1", nm, dones);
    end
    total++;
    if (len != n) begin
      bad++;
      $display("FAIL %s frame_length: got %0d bit periods, required %0d", nm, len, n);
    end
    if (!hold) begin
      bus.tx_valid = 1'b0;
      @(posedge clk); #1;
      total++;
      if (tx_done !== 1'b0 || busy !== 1'b0 || txd !== 1'b1) begin
        bad++;
        $display("FAIL %s after_done: tx_done=%b busy=%b txd=%b, required 0 0 1", nm, tx_done, busy, txd);
      end
    end
  endtask

  task automatic test_reset();
    int idle_bad;
    rst = 1'b1;
    bclk_man = 1'b1;
    bclk = 1'b1;
    bus.tx_valid = 1'b1;
    bus.tx_data = 8'hA5;
    bus.parity_en = 1'b1;
    bus.parity_odd = 1'b1;
    bus.stop2 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (txd !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0 || bus.tx_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_state: txd=%b busy=%b tx_done=%b tx_ready=%b, required 1 0 0 1",
               txd, busy, tx_done, bus.tx_ready);
    end
    rst = 1'b0;
    bus.tx_valid = 1'b0;
    bclk = 1'b0;
    bclk_man = 1'b0;
    idle_bad = 0;
    repeat (3 * bper) begin
      @(posedge clk); #1;
      if (txd !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) idle_bad++;
    end
    total++;
    if (idle_bad != 0) begin
      bad++;
      $display("FAIL idle_ignores_bclk: %0d idle cycles off, required 0", idle_bad);
    end
  endtask

  task automatic test_basic();
    int w;
    bper = 16;
    run_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, "frame_55", w);
  endtask

  task automatic test_parity();
    int w;
    bper = 16;
    run_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "parity_even_07", w);
    run_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, "parity_odd_07", w);
  endtask

  task automatic test_stop2();
    int w;
    bper = 16;
    run_frame(8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, "stop2_ff", w);
  endtask

  task automatic test_back_to_back();
    int w1, w2;
    bper = 16;
    run_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, "b2b_a5", w1);
    run_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, "b2b_3c", w2);
    total++;
    if (w2 != 1) begin
      bad++;
      $display("FAIL b2b_handshake_gap: second handshake after %0d cycles, required 1", w2);
    end
  endtask

  task automatic test_coincident();
    int hold_bad;
    bclk_man = 1'b1;
    bclk = 1'b0;
    @(posedge clk); #1;
    bus.tx_data = 8'($urandom);
    bus.parity_en = 1'b0;
    bus.parity_odd = 1'b0;
    bus.stop2 = 1'b0;
    bus.tx_valid = 1'b1;
    bclk = 1'b1;
    @(posedge clk); #1;
    bus.tx_valid = 1'b0;
    bclk = 1'b0;
    total++;
    if (hs_seen !== 1'b1 || busy !== 1'b1 || txd !== 1'b1) begin
      bad++;
      $display("FAIL coinc_sync: hs=%b busy=%b txd=%b, required 1 1 1", hs_seen, busy, txd);
    end
    hold_bad = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (txd !== 1'b1 || busy !== 1'b1) hold_bad++;
    end
    total++;
    if (hold_bad != 0) begin
      bad++;
      $display("FAIL coinc_wait: %0d cycles left SYNC early, required 0", hold_bad);
    end
    bclk = 1'b1;
    @(posedge clk); #1;
    bclk = 1'b0;
    hold_bad = 0;
    repeat (4) begin
      if (txd !== 1'b0 || busy !== 1'b1) hold_bad++;
      @(posedge clk); #1;
    end
    total++;
    if (hold_bad != 0) begin
      bad++;
      $display("FAIL coinc_start: %0d cycles not holding start bit, required 0", hold_bad);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bclk_man = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    int ticks, c, done_seen, txd_bad;
    bper = 16;
    d = 8'($urandom);
    bus.tx_data = d;
    bus.parity_en = 1'($urandom);
    bus.parity_odd = 1'($urandom);
    bus.stop2 = 1'($urandom);
    bus.tx_valid = 1'b1;
    c = 0;
    do begin
      @(posedge clk); #1;
      c++;
    end while (!hs_seen && c < 400);
    bus.tx_valid = 1'b0;
    ticks = 0;
    c = 0;
    while (ticks < 5 && c < 500) begin
      @(posedge clk); #1;
      if (bclk_seen) ticks++;
      c++;
    end
    total++;
    if (ticks != 5 || txd !== d[3]) begin
      bad++;
      $display("FAIL mid_bit3: ticks=%0d txd=%b, required ticks=5 txd=%b", ticks, txd, d[3]);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if (txd !== 1'b1 || busy !== 1'b0 || bus.tx_ready !== 1'b1 || tx_done !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: txd=%b busy=%b tx_ready=%b tx_done=%b, required 1 0 1 0",
               txd, busy, bus.tx_ready, tx_done);
    end
    done_seen = 0;
    txd_bad = 0;
    repeat (5 * bper) begin
      @(posedge clk); #1;
      if (tx_done === 1'b1) done_seen++;
      if (txd !== 1'b1) txd_bad++;
    end
    total++;
    if (done_seen != 0 || txd_bad != 0) begin
      bad++;
      $display("FAIL mid_abort: tx_done pulses=%0d low cycles=%0d, required 0 0", done_seen, txd_bad);
    end
  endtask

  task automatic test_random();
    int w;
    for (int k = 0; k < 8; k++) begin
      bper = $urandom_range(1, 20);
      run_frame(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 8'h00, "random", w);
    end
  endtask

  initial begin
    bus.tx_valid   = 1'b0;
    bus.tx_data    = 8'h00;
    bus.parity_en  = 1'b0;
    bus.parity_odd = 1'b0;
    bus.stop2      = 1'b0;
    test_reset();
    test_basic();
    test_parity();
    test_stop2();
    test_back_to_back();
    test_coincident();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
